bcd_seg7_scan: RTL and testbench
================================

Name: bcd_seg7_scan

Overview:
- Consumes the 3-digit BCD output of the 8-bit binary-to-BCD decoder (hundreds/tens/ones) plus a sign flag.
- Drives a 4-digit common-anode or common-cathode multiplexed 7-segment display on the PS/2 mouse board.
- Digits are double-buffered. A new value presented on load is applied only at a scan-frame boundary, so no frame ever mixes old and new digits.
- Scan order is digit 0 (ones) → 1 (tens) → 2 (hundreds) → 3 (sign), then repeat.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal minimum is 2.
- SEG_ACTIVE_LOW, 1, when 1 the seg and an outputs are active-low (all-off = all 1s); when 0 they are active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- load  in  1  one-cycle strobe; captures neg/hundreds/tens/ones into the shadow register
- neg  in  1  sign of the mouse delta; 1 displays '-' on digit 3
- hundreds  in  2  BCD hundreds digit (0..2)
- tens  in  4  BCD tens digit
- ones  in  4  BCD ones digit
- seg  out  7  segments {g,f,e,d,c,b,a}, registered
- an  out  4  digit enables, one-hot, registered
- frame_done  out  1  one-cycle pulse at the end of digit slot 3

Behaviour:
- Reset (async, rst=1):
  - cnt=0, idx=0, shadow=0, active=0, pending=0.
  - seg=all-off, an=all-off, frame_done=0.
- Prescaler:
  - cnt counts 0..SCAN_DIV-1 and wraps.
  - tick = (cnt==SCAN_DIV-1).
  - On tick, idx increments mod 4 (3 wraps to 0).
- Output registers: updated every cycle from the current cnt/idx/active.
  - Outputs lag the counters by exactly one cycle.
  - an = all-off when tick (one dead-time cycle per slot, anti-ghosting); otherwise onehot(idx).
  - seg = encode(digit[idx]).
- Digit encoding (active-high values):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - BCD code 10..15 → blank (00).
  - Digit 3 = 40 ('-') when neg=1, blank when neg=0.
  - When SEG_ACTIVE_LOW=1, both seg and an are inverted.
- Load:
  - On load=1, shadow ← inputs and pending ← 1.
  - A later load before the frame boundary overwrites shadow (last value wins).
- Frame boundary (tick while idx==3):
  - frame_done=1 in the following cycle.
  - If pending=1: active ← shadow and pending ← 0.
- Simultaneous load and frame boundary: active ← the live inputs directly (bypass) and pending ← 0.
- Reset mid-frame: all state cleared immediately. The first lit digit is digit 0, one cycle after rst deasserts.
- Refresh rate = f_clk / (4·SCAN_DIV).

Optional Feature:
- Macro: BCD_SEG7_LZ_BLANK_EN
- Defined: leading-zero blanking.
  - hundreds==0 blanks digit 2.
  - hundreds==0 and tens==0 blanks digit 1.
  - Digit 0 is never blanked.
  - Evaluated on active, not shadow.
- Undefined: all three numeric digits are always shown, including zeros.
- The sign digit is unaffected either way.

Decomposition:
- Shared package/include (bcd_seg7_defs) holds:
  - the 7-bit segment constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK;
  - the digit index constants DIG_ONES=0, DIG_TENS=1, DIG_HUND=2, DIG_SIGN=3.
- One natural sub-module: seg7_encode, combinational, 4-bit code → 7-bit active-high pattern. Instantiate it once on the muxed digit.

Test Plan (SCAN_DIV=4, SEG_ACTIVE_LOW=0):
- Reset then load 1/3/7 with neg=0 → after the first frame boundary: slot0 seg=07, slot1 seg=4F, slot2 seg=06, slot3 seg=00; an=0001/0010/0100/1000 for 3 cycles each, plus 0000 for 1 cycle.
- Load 2/5/5 mid-frame (idx=1) → current frame still shows the old value; 255 appears starting at the next slot0; frame_done pulses once every 16 cycles.
- Load coincident with the tick at idx==3 → the new value appears in the immediately following slot0; pending=0 afterwards.
- neg=1 with 0/4/2 → slot3 seg=40. With BCD_SEG7_LZ_BLANK_EN: slot2 seg=00, slot1 seg=66. Without the macro: slot2 seg=3F.
- 0/0/0 with the macro defined → slots 1 and 2 blank, slot0 seg=3F. Code tens=A → slot1 blank in either build.
- Assert rst for 2 cycles during slot 2 → seg/an go all-off asynchronously; after release the scan restarts at slot0 with active=0 (seg=3F, plus the blanking rules if the macro is defined).

Source files
------------

// File: rtl/bcd_seg7_defs.sv
// Shared definitions for the BCD seven-segment scanner:
// segment patterns (active-high, {g,f,e,d,c,b,a}), digit slot indices,
// and the packed record holding one displayable value.
package bcd_seg7_defs;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit slot indices, in scan order
  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_HUND = 2'd2;
  localparam logic [1:0] DIG_SIGN = 2'd3;

  // Code fed to the encoder when a numeric digit must be dark
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // One complete display value as delivered by the binary-to-BCD decoder
  typedef struct packed {
    logic       neg;
    logic [1:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_value_t;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD-to-seven-segment encoder.
// Produces the active-high pattern; codes 10..15 render as blank.
module seg7_encode
  import bcd_seg7_defs::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // Map each BCD code onto its segment pattern, blank for non-decimal codes
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Four-digit multiplexed seven-segment scanner for a signed 3-digit BCD value.
// Values are double-buffered: a load lands in a shadow register and is only
// promoted to the displayed (active) value at a scan-frame boundary, so a
// frame never mixes old and new digits.
// Optional build macro BCD_SEG7_LZ_BLANK_EN: leading-zero blanking of the
// hundreds and tens digits (evaluated on the active value).
// SCAN_DIV must be at least 2.
module bcd_seg7_scan
  import bcd_seg7_defs::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       neg,
  input  logic [1:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int              CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0]      AN_OFF   = SEG_ACTIVE_LOW ? 4'hF : 4'h0;

  // Prescaler and slot index
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             tick;
  logic             boundary;

  // Double buffer
  bcd_value_t       live;
  bcd_value_t       shadow_q, shadow_d;
  bcd_value_t       active_q, active_d;
  logic             pending_q, pending_d;

  // Output registers
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;
  logic             frame_done_q, frame_done_d;

  // Digit selection / encoding
  logic [3:0]       digit_code;
  logic [6:0]       enc_pattern;
  logic [6:0]       pattern;
  logic [3:0]       an_onehot;

  assign live     = '{neg: neg, hundreds: hundreds, tens: tens, ones: ones};
  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (idx_q == DIG_SIGN);

  // Prescaler wraps at SCAN_DIV-1; the slot index advances on each wrap
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Shadow/active handoff: loads park in the shadow until the frame boundary;
  // a load that coincides with the boundary goes straight to the display
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d = live;
      if (boundary) begin
        active_d  = live;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  // Pick the numeric code for the current slot, applying optional blanking
  always_comb begin
    digit_code = CODE_BLANK;
    case (idx_q)
      DIG_ONES: digit_code = active_q.ones;
      DIG_TENS: begin
        digit_code = active_q.tens;
`ifdef BCD_SEG7_LZ_BLANK_EN
        if ((active_q.hundreds == 2'd0) && (active_q.tens == 4'd0)) begin
          digit_code = CODE_BLANK;
        end
`endif
      end
      DIG_HUND: begin
        digit_code = {2'b00, active_q.hundreds};
`ifdef BCD_SEG7_LZ_BLANK_EN
        if (active_q.hundreds == 2'd0) begin
          digit_code = CODE_BLANK;
        end
`endif
      end
      default: digit_code = CODE_BLANK;
    endcase
  end

  seg7_encode u_encode (
    .code_i (digit_code),
    .seg_o  (enc_pattern)
  );

  // The sign slot bypasses the encoder: minus or dark
  always_comb begin
    pattern = enc_pattern;
    if (idx_q == DIG_SIGN) begin
      pattern = active_q.neg ? SEG_MINUS : SEG_BLANK;
    end
  end

  // One-hot digit enable from the slot index
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_an
      assign an_onehot[gi] = (idx_q == 2'(gi));
    end
  endgenerate

  // Next output values; anodes go dark on the last cycle of each slot so the
  // segment change never bleeds into the neighbouring digit
  always_comb begin
    seg_d        = SEG_ACTIVE_LOW ? ~pattern : pattern;
    an_d         = SEG_ACTIVE_LOW ? ~an_onehot : an_onehot;
    frame_done_d = boundary;
    if (tick) begin
      an_d = AN_OFF;
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= DIG_ONES;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Self-checking bench for bcd_seg7_scan (SCAN_DIV=4, active-high outputs).
// Honours BCD_SEG7_LZ_BLANK_EN for the expected blanking of leading zeros.
module tb_bcd_seg7_scan;

  localparam int SD = 4;
`ifdef BCD_SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  // Pattern of a leading zero in the hundreds/tens slot
  localparam logic [6:0] ZL = LZ ? 7'h00 : 7'h3F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       neg = 1'b0;
  logic [1:0] hundreds = 2'd0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;

  always #5 clk = ~clk;

  bcd_seg7_scan #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .neg        (neg),
    .hundreds   (hundreds),
    .tens       (tens),
    .ones       (ones),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic            neg;
    logic [1:0]      h;
    logic [3:0]      t;
    logic [3:0]      o;
    logic [3:0][6:0] exp;   // expected seg per slot 0..3
  } vec_t;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
  } obs_t;

  obs_t            sb[$];
  int              n_cmp = 0;
  int              n_bad = 0;
  int              m_cyc;
  logic            m_pend;
  logic [3:0][6:0] cur_exp, sh_exp, rst_exp;
  vec_t            tbl[9];
  vec_t            hold;

  function automatic vec_t mk(input logic n, input logic [1:0] h, input logic [3:0] t,
                              input logic [3:0] o, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
    vec_t v;
    v.neg = n; v.h = h; v.t = t; v.o = o;
    v.exp[0] = s0; v.exp[1] = s1; v.exp[2] = s2; v.exp[3] = s3;
    return v;
  endfunction

  task automatic compare(input string name, input obs_t g);
    obs_t e;
    e = sb.pop_front();
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got seg=%h an=%b fd=%b, want seg=%h an=%b fd=%b",
               name, m_cyc, g.seg, g.an, g.fd, e.seg, e.an, e.fd);
    end
  endtask

  task automatic reset_model();
    m_cyc   = 0;
    m_pend  = 1'b0;
    cur_exp = rst_exp;
    sh_exp  = rst_exp;
  endtask

  // Check the all-off output state (used while rst is high)
  task automatic check_off(input string name);
    obs_t e, g;
    e = '0;
    sb.push_back(e);
    g.seg = seg; g.an = an; g.fd = frame_done;
    compare(name, g);
  endtask

  // One clock: drive inputs, predict the output registered at this edge, compare
  task automatic step(input logic ld, input vec_t v);
    obs_t e, g;
    int   c, slot;
    c    = m_cyc % 16;
    slot = c / 4;
    load = ld; neg = v.neg; hundreds = v.h; tens = v.t; ones = v.o;
    e.seg = cur_exp[slot];
    e.an  = (c % 4 == 3) ? 4'b0000 : 4'(1 << slot);
    e.fd  = (c == 15);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (ld && c == 15) begin
      cur_exp = v.exp;
      m_pend  = 1'b0;
    end else if (ld) begin
      sh_exp = v.exp;
      m_pend = 1'b1;
    end else if (c == 15 && m_pend) begin
      cur_exp = sh_exp;
      m_pend  = 1'b0;
    end
    g.seg = seg; g.an = an; g.fd = frame_done;
    compare("scan", g);
    m_cyc++;
  endtask

  task automatic run_until(input int p, input vec_t v);
    for (int k = 0; k < 16 && (m_cyc % 16) != p; k++) step(1'b0, v);
  endtask

  task automatic run(input int n, input vec_t v);
    for (int k = 0; k < n; k++) step(1'b0, v);
  endtask

  initial begin
    rst_exp[0] = 7'h3F; rst_exp[1] = ZL; rst_exp[2] = ZL; rst_exp[3] = 7'h00;

    //            neg  h     t     o      slot0  slot1  slot2  slot3
    tbl[0] = mk(1'b0, 2'd1, 4'd3, 4'd7, 7'h07, 7'h4F, 7'h06, 7'h00);
    tbl[1] = mk(1'b0, 2'd2, 4'd5, 4'd5, 7'h6D, 7'h6D, 7'h5B, 7'h00);
    tbl[2] = mk(1'b1, 2'd0, 4'd4, 4'd2, 7'h5B, 7'h66, ZL,    7'h40);
    tbl[3] = mk(1'b0, 2'd0, 4'd0, 4'd0, 7'h3F, ZL,    ZL,    7'h00);
    tbl[4] = mk(1'b1, 2'd1, 4'hA, 4'd9, 7'h6F, 7'h00, 7'h06, 7'h40);
    tbl[5] = mk(1'b1, 2'd0, 4'd0, 4'd8, 7'h7F, ZL,    ZL,    7'h40);
    tbl[6] = mk(1'b0, 2'd2, 4'd0, 4'd0, 7'h3F, 7'h3F, 7'h5B, 7'h00);
    tbl[7] = mk(1'b0, 2'd0, 4'd9, 4'd6, 7'h7D, 7'h6F, ZL,    7'h00);
    tbl[8] = mk(1'b0, 2'd0, 4'd1, 4'hF, 7'h00, 7'h06, ZL,    7'h00);
    hold = mk(1'b0, 2'd0, 4'd0, 4'd0, 7'h00, 7'h00, 7'h00, 7'h00);

    // Reset state, then one frame of the cleared value
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_off("reset_hold");
    rst = 1'b0;
    reset_model();
    $display("reset released: scanning cleared value");
    run(16, hold);

    // Table: each value loaded at a different frame position
    for (int i = 0; i < 9; i++) begin
      run_until((i * 5) % 16, hold);
      $display("vec %0d: load neg=%0d h=%0d t=%0h o=%0h at pos %0d",
               i, tbl[i].neg, tbl[i].h, tbl[i].t, tbl[i].o, m_cyc % 16);
      step(1'b1, tbl[i]);
      hold = tbl[i];
      run(32, hold);
    end

    // Mid-frame load at idx=1, then a second load before the boundary: last wins
    run_until(5, hold);
    $display("double load: 137 then 255 within one frame");
    step(1'b1, tbl[0]);
    run_until(9, tbl[0]);
    step(1'b1, tbl[1]);
    hold = tbl[1];
    run(40, hold);

    // Load coincident with the frame boundary shows in the very next slot 0
    run_until(15, hold);
    $display("boundary load: neg 042");
    step(1'b1, tbl[2]);
    hold = tbl[2];
    run(36, hold);

    // Reset pulse during slot 2: outputs clear at once, scan restarts at slot 0
    run_until(10, hold);
    $display("reset during slot 2");
    rst = 1'b1;
    #1;
    check_off("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_off("reset_mid");
    rst = 1'b0;
    reset_model();
    run(36, hold);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
